// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with a fixed latency.
// One shift-add (multiply) or restoring-divide step is done per cycle over
// unsigned operand magnitudes. Signs are reapplied in a final FIX cycle.
module muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [2:0]        func_i,
    input  logic [DATA_W-1:0] op_a_i,
    input  logic [DATA_W-1:0] op_b_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    localparam logic [2:0] FUNC_MUL    = 3'b000;
    localparam logic [2:0] FUNC_MULH   = 3'b001;
    localparam logic [2:0] FUNC_MULHSU = 3'b010;
    localparam logic [2:0] FUNC_MULHU  = 3'b011;
    localparam logic [2:0] FUNC_DIV    = 3'b100;
    localparam logic [2:0] FUNC_DIVU   = 3'b101;
    localparam logic [2:0] FUNC_REM    = 3'b110;
    localparam logic [2:0] FUNC_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [2:0]        r_func;
    logic [DATA_W-1:0] r_aMag;
    logic [DATA_W-1:0] r_bMag;
    logic              r_negRes;
    logic              r_negRem;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W-1:0] r_result;

    logic              w_accept;
    logic              w_aSigned;
    logic              w_bSigned;
    logic              w_aNeg;
    logic              w_bNeg;
    logic              w_divZero;
    logic [DATA_W-1:0] w_aMag;
    logic [DATA_W-1:0] w_bMag;

    logic [DATA_W:0]     w_mulSum;
    logic [DATA_W:0]     w_remShift;
    logic [DATA_W:0]     w_trial;
    logic [2*DATA_W-1:0] w_product;
    logic [2*DATA_W-1:0] w_prodFixed;
    logic [DATA_W-1:0]   w_quoFixed;
    logic [DATA_W-1:0]   w_remFixed;
    logic [DATA_W-1:0]   w_resultSel;

    // Operand decode at issue: signedness per funct3, then unsigned magnitudes.
    // A signed minimum operand maps to 2^(DATA_W-1), which still fits unsigned.
    assign w_accept   = (r_state == S_IDLE) && start_i && !flush_i;
    assign w_aSigned  = (func_i != FUNC_MULHU) && (func_i != FUNC_DIVU) && (func_i != FUNC_REMU);
    assign w_bSigned  = w_aSigned && (func_i != FUNC_MULHSU);
    assign w_aNeg     = w_aSigned && op_a_i[DATA_W-1];
    assign w_bNeg     = w_bSigned && op_b_i[DATA_W-1];
    assign w_aMag     = w_aNeg ? (-op_a_i) : op_a_i;
    assign w_bMag     = w_bNeg ? (-op_b_i) : op_b_i;
    assign w_divZero  = (op_b_i == '0);

    // Single iteration datapaths; r_hi/r_lo hold {accumulator, multiplier} for
    // multiply and {partial remainder, dividend/quotient} for divide.
    assign w_mulSum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_aMag} : '0);
    assign w_remShift  = {r_hi, r_lo[DATA_W-1]};
    assign w_trial     = w_remShift - {1'b0, r_bMag};

    // Sign correction applied in FIX.
    assign w_product   = {r_hi, r_lo};
    assign w_prodFixed = r_negRes ? (-w_product) : w_product;
    assign w_quoFixed  = r_negRes ? (-r_lo) : r_lo;
    assign w_remFixed  = r_negRem ? (-r_hi) : r_hi;

    // Result word selection by funct3.
    always_comb begin
        w_resultSel = '0;
        case (r_func)
            FUNC_MUL:                           w_resultSel = w_prodFixed[DATA_W-1:0];
            FUNC_MULH, FUNC_MULHSU, FUNC_MULHU: w_resultSel = w_prodFixed[2*DATA_W-1:DATA_W];
            FUNC_DIV, FUNC_DIVU:                w_resultSel = w_quoFixed;
            FUNC_REM, FUNC_REMU:                w_resultSel = w_remFixed;
            default:                            w_resultSel = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nextState;
    end

    // Next-state logic; flush aborts any operation in flight.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_nextState = S_CALC;
            S_CALC: begin
                if (flush_i)                 w_nextState = S_IDLE;
                else if (r_cnt == LAST_STEP) w_nextState = S_FIX;
            end
            S_FIX:   w_nextState = flush_i ? S_IDLE : S_DONE;
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Operand capture, iteration steps and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_func   <= '0;
            r_aMag   <= '0;
            r_bMag   <= '0;
            r_negRes <= 1'b0;
            r_negRem <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_func   <= func_i;
                        r_aMag   <= w_aMag;
                        r_bMag   <= w_bMag;
                        // Quotient keeps positive sign on divide-by-zero so it stays all-ones.
                        r_negRes <= (w_aNeg ^ w_bNeg) && !(func_i[2] && w_divZero);
                        r_negRem <= w_aNeg;
                        r_cnt    <= '0;
                        r_hi     <= '0;
                        r_lo     <= func_i[2] ? w_aMag : w_bMag;
                    end
                end
                S_CALC: begin
                    r_cnt <= (r_cnt == LAST_STEP) ? '0 : r_cnt + 1'b1;
                    if (r_func[2]) begin
                        r_hi <= w_trial[DATA_W] ? w_remShift[DATA_W-1:0] : w_trial[DATA_W-1:0];
                        r_lo <= {r_lo[DATA_W-2:0], ~w_trial[DATA_W]};
                    end else begin
                        r_hi <= w_mulSum[DATA_W:1];
                        r_lo <= {w_mulSum[0], r_lo[DATA_W-1:1]};
                    end
                end
                S_FIX: begin
                    if (!flush_i) r_result <= w_resultSel;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy_o   = (r_state != S_IDLE);
    assign done_o   = (r_state == S_DONE);
    assign result_o = r_result;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative RV32M multiply/divide unit for the integer execute stage.
- Covers all eight M-extension funct3 encodings: mul, mulh, mulhsu, mulhu, div, divu, rem, remu.
- Performs one shift-add or restoring-divide step per cycle, with a fixed latency independent of operand values.
- Uses a start/busy/done handshake and accepts a pipeline flush.

Parameters:
- DATA_W, 32, operand and result width (equals `data_size); must be even and at least 4.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start_i  input  1  request an operation; sampled only in IDLE.
- func_i  input  3  RV32M funct3 (`mul_func .. `remu_func); sampled with start_i.
- op_a_i  input  DATA_W  rs1 operand (multiplicand or dividend); sampled with start_i.
- op_b_i  input  DATA_W  rs2 operand (multiplier or divisor); sampled with start_i.
- flush_i  input  1  abort the operation in flight.
- busy_o  output  1  high from the cycle after start is accepted until the DONE cycle ends.
- done_o  output  1  one-cycle pulse; result_o is valid in that cycle.
- result_o  output  DATA_W  result; holds its value until the next done_o.

Behaviour:
- Reset (asynchronous, rst_n=0, in any state):
  - state goes to IDLE; busy_o=0, done_o=0, result_o=0; all internal registers cleared.
  - Takes effect immediately, including mid-operation.
- States: IDLE, CALC, FIX, DONE.
  - IDLE: start_i=1 and flush_i=0 at a rising edge latches func_i, op_a_i and op_b_i.
    - Computes operand magnitudes and records the required result sign.
    - Signedness: mul/mulh/div/rem treat both operands as signed; mulhsu treats A as signed and B as unsigned; mulhu/divu/remu treat both as unsigned.
    - Clears the step counter and goes to CALC. busy_o becomes 1.
  - CALC: one iteration per edge; counter increments.
    - Multiply: 2*DATA_W-bit accumulator, shift-add over the magnitudes.
    - Divide: restoring step (shift remainder, trial subtract divisor, set quotient bit).
    - After DATA_W iterations (counter wraps from DATA_W-1), go to FIX.
  - FIX: apply sign correction.
    - Product: two's complement of the full 2*DATA_W result if the sign is negative.
    - Quotient: negated if operand signs differ.
    - Remainder: takes the sign of the dividend.
    - Select the output word:
      - mul: low half of the product.
      - mulh/mulhsu/mulhu: high half of the product.
      - div/divu: quotient.
      - rem/remu: remainder.
    - Register result_o and go to DONE.
  - DONE: done_o=1 for exactly this cycle and busy_o=1; next edge returns to IDLE.
- Latency: done_o is high exactly DATA_W+2 cycles after the cycle in which start was accepted (34 cycles for DATA_W=32).
  - Back-to-back: a new start_i is accepted in the cycle right after DONE, so throughput is one operation per DATA_W+3 cycles.
- Special cases (fixed latency, no early exit):
  - Divide by zero: div/divu give all-ones; rem/remu give op_a.
  - Signed overflow (op_a = -2^(DATA_W-1), op_b = -1): div gives op_a; rem gives 0.
- start_i is ignored while busy_o=1.
- flush_i=1 at an edge in CALC, FIX or DONE:
  - Next state is IDLE, busy_o=0, done_o=0.
  - result_o keeps its previous value; no done_o is produced for the aborted operation.
  - flush_i and start_i high together in IDLE: flush wins and start is dropped.
- The 0 to 2^(DATA_W-1) magnitude of a signed minimum operand must be represented without overflow, using DATA_W-bit unsigned magnitudes.
- No combinational path from any input to any output.

Test Plan:
1. mul 7 x 0xFFFFFFFD (-3) -> done_o after 34 cycles, result_o=0xFFFFFFEB. mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
2. mulh 0x80000000 x 0x80000000 -> 0x40000000. mulhsu 0xFFFFFFFF (signed -1) x 0xFFFFFFFF (unsigned) -> 0xFFFFFFFF.
3. div 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. rem on the same operands -> 0xFFFFFFFF. divu 100/7 -> 14; remu 100/7 -> 2.
4. divu 5/0 -> 0xFFFFFFFF; remu 5/0 -> 5. div 0x80000000 / 0xFFFFFFFF -> 0x80000000; rem on the same operands -> 0.
5. Start a mul, assert flush_i at cycle 10 -> busy_o=0 next cycle, no done_o, result_o unchanged. A start in the following cycle is accepted and completes normally. A start_i pulsed while busy is ignored.
6. Deassert rst_n asynchronously mid-division (cycle 20) -> busy_o, done_o and result_o go to 0 immediately. After release, a divu 9/3 gives 3 at the nominal latency. Rerun scenarios 1 and 3 with DATA_W=16 and check latency is 18 cycles.
